// File: rtl/sysid_check_master.sv
// Avalon-MM master that reads the system-ID slave (ID, then timestamp), compares both
// against build-time values and reports pass/fail without CPU involvement.
module sysid_check_master #(
  parameter logic [31:0] EXP_ID        = 32'h0000_0000,
  parameter logic [31:0] EXP_TIMESTAMP = 32'd1618983068,
  parameter bit          CHECK_TS      = 1'b1,
  parameter bit          AUTO_START    = 1'b1,
  parameter int unsigned TIMEOUT       = 255,
  parameter int unsigned MAX_RETRY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned TW = 8;
  localparam int unsigned RW = 2;

  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_t;

  state_t        state, state_nx;
  logic          gap, gap_nx;
  logic          armed;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [RW-1:0] retry, retry_nx;
  logic          launch, cap_id, cap_ts, to_fail;
  logic          id_mis, ts_mis;

  // Next-state: read sequencing, stall timeout and retry bookkeeping
  always_comb begin
    state_nx = state;
    gap_nx   = 1'b0;
    tcnt_nx  = tcnt;
    retry_nx = retry;
    launch   = 1'b0;
    cap_id   = 1'b0;
    cap_ts   = 1'b0;
    to_fail  = 1'b0;
    id_mis   = (id_value != EXP_ID);
    ts_mis   = CHECK_TS && (ts_value != EXP_TIMESTAMP);
    unique case (state)
      IDLE: begin
        if (start || (AUTO_START && !armed)) begin
          state_nx = RD_ID;
          launch   = 1'b1;
          retry_nx = '0;
          tcnt_nx  = '0;
        end
      end
      RD_ID, RD_TS: begin
        // gap=1 is the one idle bus cycle separating a timed-out read from its retry
        if (gap) begin
          tcnt_nx = '0;
        end else if (!av_waitrequest) begin
          tcnt_nx = '0;
          if (state == RD_ID) begin
            cap_id   = 1'b1;
            state_nx = CHECK_TS ? RD_TS : CHECK;
          end else begin
            cap_ts   = 1'b1;
            state_nx = CHECK;
          end
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          tcnt_nx = '0;
          if (retry < RW'(MAX_RETRY)) begin
            retry_nx = retry + RW'(1);
            state_nx = RD_ID;
            gap_nx   = 1'b1;
          end else begin
            to_fail  = 1'b1;
            state_nx = DONE;
          end
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      CHECK:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs; bus strobes derive from the next state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gap         <= 1'b0;
      armed       <= 1'b0;
      tcnt        <= '0;
      retry       <= '0;
      av_read     <= 1'b0;
      av_address  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state      <= state_nx;
      gap        <= gap_nx;
      armed      <= 1'b1;
      tcnt       <= tcnt_nx;
      retry      <= retry_nx;
      av_read    <= ((state_nx == RD_ID) || (state_nx == RD_TS)) && !gap_nx;
      av_address <= (state_nx == RD_TS);
      busy       <= (state_nx inside {RD_ID, RD_TS, CHECK});
      done       <= (state_nx == DONE);
      if (cap_id) id_value <= av_readdata;
      if (cap_ts) ts_value <= av_readdata;
      if (launch) begin
        pass        <= 1'b0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
        timeout_err <= 1'b0;
      end
      // Result is resolved on entry to DONE so pass is already valid during the done pulse
      if (state == CHECK) begin
        id_mismatch <= id_mis;
        ts_mismatch <= ts_mis;
        pass        <= !(id_mis || ts_mis);
      end
      if (to_fail) begin
        timeout_err <= 1'b1;
        pass        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master: scoreboard of expected results per accepted start,
// popped and compared on each done pulse.
module tb_sysid_check_master;

  localparam logic [31:0] EXP_TS = 32'd1618983068;

  logic        clock;
  logic        reset_n;
  logic        start_a, wr_a, start_b, wr_b;
  logic [31:0] slave_id, slave_ts, rdata_a, rdata_b;
  logic        rd_a, addr_a, busy_a, done_a, pass_a, idm_a, tsm_a, toe_a;
  logic        rd_b, addr_b, busy_b, done_b, pass_b, idm_b, tsm_b, toe_b;
  logic [31:0] idv_a, tsv_a, idv_b, tsv_b;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit sel = 1'b0;

  typedef struct {
    logic        pass, idm, tsm, toe;
    logic [31:0] idv, tsv;
    int          due;
  } exp_t;
  exp_t sb[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign rdata_a = addr_a ? slave_ts : slave_id;
  assign rdata_b = addr_b ? slave_ts : slave_id;

  sysid_check_master #(.TIMEOUT(4), .MAX_RETRY(2), .CHECK_TS(1'b1), .AUTO_START(1'b1)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a),
    .av_address(addr_a), .av_read(rd_a), .av_readdata(rdata_a), .av_waitrequest(wr_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .id_mismatch(idm_a), .ts_mismatch(tsm_a), .timeout_err(toe_a),
    .id_value(idv_a), .ts_value(tsv_a)
  );

  sysid_check_master #(.CHECK_TS(1'b0), .AUTO_START(1'b0)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b),
    .av_address(addr_b), .av_read(rd_b), .av_readdata(rdata_b), .av_waitrequest(wr_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .id_mismatch(idm_b), .ts_mismatch(tsm_b), .timeout_err(toe_b),
    .id_value(idv_b), .ts_value(tsv_b)
  );

  // Observed signals of whichever instance is under test
  logic        o_rd, o_addr, o_busy, o_done, o_pass, o_idm, o_tsm, o_toe;
  logic [31:0] o_idv, o_tsv;
  assign o_rd   = sel ? rd_b   : rd_a;
  assign o_addr = sel ? addr_b : addr_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_pass = sel ? pass_b : pass_a;
  assign o_idm  = sel ? idm_b  : idm_a;
  assign o_tsm  = sel ? tsm_b  : tsm_a;
  assign o_toe  = sel ? toe_b  : toe_a;
  assign o_idv  = sel ? idv_b  : idv_a;
  assign o_tsv  = sel ? tsv_b  : tsv_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic p, input logic idm, input logic tsm, input logic toe,
                      input logic [31:0] idv, input logic [31:0] tsv, input int due);
    exp_t e;
    e.pass = p; e.idm = idm; e.tsm = tsm; e.toe = toe;
    e.idv = idv; e.tsv = tsv; e.due = due;
    sb.push_back(e);
  endtask

  // Runs cycles until every queued result is seen plus a quiet tail; acts as the slave's waitrequest
  task automatic run(input int max, input int stall_ts, input bit stuck, input logic [15:0] mask,
                     output int attempts, output int addr1);
    int   n, tail, ndone, nexp, stalls, low_run;
    bit   prev_rd, wr_prev;
    exp_t e;
    n = 0; tail = 0; ndone = 0; nexp = sb.size(); stalls = stall_ts;
    low_run = 0; prev_rd = 1'b0; wr_prev = 1'b0; attempts = 0; addr1 = 0;
    while (n < max && (sb.size() > 0 || tail > 0)) begin
      @(negedge clock);
      n++;
      if (sb.size() == 0) tail--;
      start_a = 1'b0;
      start_b = 1'b0;
      if (n < 16 && mask[4'(n)]) begin
        if (sel) start_b = 1'b1; else start_a = 1'b1;
      end
      if (o_rd && !prev_rd) begin
        if (stuck && attempts > 0) chk("retry_gap", 32'(low_run), 32'd1);
        attempts++;
        low_run = 0;
      end else if (o_busy && !o_rd) begin
        low_run++;
      end
      prev_rd = o_rd;
      if (o_rd && o_addr) addr1++;
      if (!stuck && wr_prev) begin
        chk("hold_read", 32'(o_rd), 32'd1);
        chk("hold_addr", 32'(o_addr), 32'd1);
      end
      if (o_done) begin
        ndone++;
        tail = 6;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("done_edge", 32'(cyc + 1), 32'(e.due));
          chk("pass", 32'(o_pass), 32'(e.pass));
          chk("id_mismatch", 32'(o_idm), 32'(e.idm));
          chk("ts_mismatch", 32'(o_tsm), 32'(e.tsm));
          chk("timeout_err", 32'(o_toe), 32'(e.toe));
          chk("id_value", o_idv, e.idv);
          chk("ts_value", o_tsv, e.tsv);
          chk("busy_at_done", 32'(o_busy), 32'd0);
        end
      end
      if (stuck && o_rd) wr_a = 1'b1;
      else if (!stuck && o_rd && o_addr && stalls > 0) begin
        wr_a = 1'b1;
        stalls--;
      end else wr_a = 1'b0;
      wr_prev = wr_a;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    wr_a    = 1'b0;
    chk("done_count", 32'(ndone), 32'(nexp));
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, r, att, a1;
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
    slave_id = 32'h0; slave_ts = EXP_TS;
    repeat (2) @(negedge clock);
    chk("rst_read", 32'(rd_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_id_value", idv_a, 32'h0);
    chk("rst_b_busy", 32'(busy_b), 32'd0);

    // Auto-start after reset release
    reset_n = 1'b1;
    r = cyc;
    push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, EXP_TS, r + 5);
    run(60, 0, 1'b0, 16'h0, att, a1);
    chk("auto_addr1_reads", 32'(a1), 32'd1);
    chk("pass_held", 32'(pass_a), 32'd1);

    // T1 clean check
    @(negedge clock); start_a = 1'b1; k = cyc + 1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, EXP_TS, k + 4);
    run(60, 0, 1'b0, 16'h0, att, a1);
    chk("t1_addr1_reads", 32'(a1), 32'd1);

    // T2 ID mismatch
    slave_id = 32'h0000_0001;
    @(negedge clock); start_a = 1'b1; k = cyc + 1;
    push(1'b0, 1'b1, 1'b0, 1'b0, 32'h1, EXP_TS, k + 4);
    run(60, 0, 1'b0, 16'h0, att, a1);

    // T3 three stalls on the timestamp read
    slave_id = 32'h0;
    @(negedge clock); start_a = 1'b1; k = cyc + 1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, EXP_TS, k + 7);
    run(60, 3, 1'b0, 16'h0, att, a1);

    // T4 waitrequest stuck: three attempts then timeout; captured values untouched
    slave_id = 32'hDEAD_BEEF;
    @(negedge clock); start_a = 1'b1; k = cyc + 1;
    push(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, EXP_TS, k + 15);
    run(80, 0, 1'b1, 16'h0, att, a1);
    chk("t4_attempts", 32'(att), 32'd3);
    chk("t4_pass_held", 32'(pass_a), 32'd0);

    // T6a starts while busy and on done are dropped; start in the following IDLE is taken
    slave_id = 32'h0;
    @(negedge clock); start_a = 1'b1; k = cyc + 1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, EXP_TS, k + 4);
    push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, EXP_TS, k + 9);
    run(60, 0, 1'b0, 16'b0000_0000_0011_0100, att, a1);

    // T5 reset during the timestamp read
    @(negedge clock); start_a = 1'b1;
    @(negedge clock); start_a = 1'b0;
    @(negedge clock);
    chk("t5_pre_read", 32'(rd_a), 32'd1);
    chk("t5_pre_addr", 32'(addr_a), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_read", 32'(rd_a), 32'd0);
    chk("t5_rst_busy", 32'(busy_a), 32'd0);
    chk("t5_rst_addr", 32'(addr_a), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    r = cyc;
    push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, EXP_TS, r + 5);
    run(60, 0, 1'b0, 16'h0, att, a1);

    // T6b no timestamp read when CHECK_TS=0; busy and done-coincident starts dropped
    sel = 1'b1;
    slave_ts = 32'h1234_5678;
    @(negedge clock); start_b = 1'b1; k = cyc + 1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, k + 3);
    run(60, 0, 1'b0, 16'b0000_0000_0000_1100, att, a1);
    chk("t6_addr1_reads", 32'(a1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
